// File: rtl/pc_trace_uart_pkg.sv
// rtl/pc_trace_uart_pkg.sv - shared constants, TX state type and helpers for the commit-trace UART
package trace_pkg;

  // First byte of every record, lets the host resynchronise on the stream
  localparam logic [7:0] SYNC_BYTE     = 8'hA5;
  // One record is {pc, inst}
  localparam int         REC_W         = 64;
  // SYNC plus 8 payload bytes
  localparam int         BYTES_PER_REC = 9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  // Saturating 16-bit increment used by the drop counter
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/pc_trace_uart_if.sv
// rtl/pc_trace_uart_if.sv - CPU-side trace bus: retired pc/inst in, UART line and status out
interface pc_trace_uart_if #(
  parameter int DEPTH_LOG2 = 4
);

  logic [31:0]         pc;
  logic [31:0]         inst;
  logic                trace_en;
  logic                tx;
  logic                hold;
  logic                busy;
  logic                overflow;
  logic [15:0]         drop_cnt;
  logic [DEPTH_LOG2:0] fifo_level;

  // The CPU / board side drives the commit stream and observes status
  modport master (
    output pc, inst, trace_en,
    input  tx, hold, busy, overflow, drop_cnt, fifo_level
  );

  // The trace unit consumes the commit stream and drives status
  modport slave (
    input  pc, inst, trace_en,
    output tx, hold, busy, overflow, drop_cnt, fifo_level
  );

endinterface

// File: rtl/pc_trace_uart_tx_byte.sv
// rtl/pc_trace_uart_tx_byte.sv - 8N1 byte serialiser with its own baud counter
module uart_tx_byte #(
  parameter int BAUD_DIV = 868
) (
  input  logic       clk_in,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] data,
  output logic       done,
  output logic       tx
);
  import trace_pkg::*;

  localparam int               CNT_W    = $clog2(BAUD_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DIV - 1);

  tx_state_t        state;
  logic [CNT_W-1:0] baud_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shifter;
  logic             bit_end;

  assign bit_end = (baud_cnt == CNT_LAST);
  // done fires on the last clock of the stop bit so the next byte can start
  // on the following clock without an idle gap between bytes of a record
  assign done    = (state == STOP) && bit_end;

  // Line level follows the state; idle and stop are both mark (high)
  always_comb begin
    tx = 1'b1;
    case (state)
      START:   tx = 1'b0;
      DATA:    tx = shifter[0];
      default: tx = 1'b1;
    endcase
  end

  // Bit-level sequencing: START -> 8 x DATA (LSB first) -> STOP, each BAUD_DIV clocks
  always_ff @(posedge clk_in) begin
    if (reset) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shifter  <= '0;
    end else begin
      case (state)
        IDLE: begin
          baud_cnt <= '0;
          if (start) begin
            shifter <= data;
            state   <= START;
          end
        end
        START: begin
          if (bit_end) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        DATA: begin
          if (bit_end) begin
            baud_cnt <= '0;
            shifter  <= {1'b0, shifter[7:1]};
            if (bit_idx == 3'd7) begin
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        STOP: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (start) begin
              shifter <= data;
              state   <= START;
            end else begin
              state <= IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/pc_trace_uart.sv
// rtl/pc_trace_uart.sv - commit-trace capture FIFO and 9-byte record sequencer over UART 8N1
module pc_trace_uart #(
  parameter int BAUD_DIV   = 868,
  parameter int DEPTH_LOG2 = 4,
  parameter int STALL_MODE = 0
) (
  input  logic           clk_in,
  input  logic           reset,
  pc_trace_uart_if.slave tif
);
  import trace_pkg::*;

  localparam int         DEPTH     = 1 << DEPTH_LOG2;
  localparam int         PW        = DEPTH_LOG2 + 1;
  localparam logic [3:0] LAST_BYTE = 4'(BYTES_PER_REC - 1);

  logic [REC_W-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    level;
  logic             full;
  logic             empty;

  logic [31:0]      last_pc;
  logic             last_valid;
  logic             capture;
  logic             pop;
  logic             push;
  logic             drop;
  logic             overflow_q;
  logic [15:0]      drop_cnt_q;

  logic             rec_active;
  logic [3:0]       byte_idx;
  logic [REC_W-1:0] rec_sh;
  logic             byte_start;
  logic [7:0]       byte_data;
  logic             byte_done;
  logic             tx_line;

  // Pointers carry one extra wrap bit so full and empty are distinguishable
  assign level   = wr_ptr - rd_ptr;
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                   (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);

  // A repeated pc (stall or self-jump) is recorded only once
  assign capture = tif.trace_en && (!last_valid || (tif.pc != last_pc));
  // The sequencer only pops between records, when the serialiser is idle
  assign pop     = !rec_active && !empty;
  // A simultaneous pop frees the slot being written, so full+pop still accepts
  assign push    = capture && (!full || pop);
  assign drop    = capture && full && !pop;

  // Capture tracking, FIFO pointers and drop accounting
  always_ff @(posedge clk_in) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      last_pc    <= '0;
      last_valid <= 1'b0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      if (capture) begin
        last_pc    <= tif.pc;
        last_valid <= 1'b1;
      end
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (drop) begin
        overflow_q <= 1'b1;
        drop_cnt_q <= sat_inc16(drop_cnt_q);
      end
    end
  end

  // Record storage; contents need no reset because the pointers gate every read
  always_ff @(posedge clk_in) begin
    if (push) begin
      mem[wr_ptr[DEPTH_LOG2-1:0]] <= {tif.pc, tif.inst};
    end
  end

  // Next byte for the serialiser: SYNC on pop, then payload MSB-first on each done
  always_comb begin
    byte_start = 1'b0;
    byte_data  = SYNC_BYTE;
    if (pop) begin
      byte_start = 1'b1;
      byte_data  = SYNC_BYTE;
    end else if (rec_active && byte_done && (byte_idx < LAST_BYTE)) begin
      byte_start = 1'b1;
      byte_data  = rec_sh[REC_W-1 -: 8];
    end
  end

  // Record sequencer: byte_idx counts bytes already started within the record
  always_ff @(posedge clk_in) begin
    if (reset) begin
      rec_active <= 1'b0;
      byte_idx   <= '0;
      rec_sh     <= '0;
    end else if (pop) begin
      rec_active <= 1'b1;
      byte_idx   <= '0;
      rec_sh     <= mem[rd_ptr[DEPTH_LOG2-1:0]];
    end else if (rec_active && byte_done) begin
      if (byte_idx < LAST_BYTE) begin
        byte_idx <= byte_idx + 4'd1;
        rec_sh   <= {rec_sh[REC_W-9:0], 8'h00};
      end else begin
        rec_active <= 1'b0;
      end
    end
  end

  uart_tx_byte #(
    .BAUD_DIV (BAUD_DIV)
  ) u_tx_byte (
    .clk_in (clk_in),
    .reset  (reset),
    .start  (byte_start),
    .data   (byte_data),
    .done   (byte_done),
    .tx     (tx_line)
  );

  assign tif.tx         = tx_line;
  assign tif.hold       = (STALL_MODE != 0) && (level == PW'(DEPTH));
  assign tif.busy       = (level != '0) || rec_active;
  assign tif.overflow   = overflow_q;
  assign tif.drop_cnt   = drop_cnt_q;
  assign tif.fifo_level = level;

endmodule

// File: tb/tb_pc_trace_uart.sv
// tb/tb_pc_trace_uart.sv - directed self-checking bench for pc_trace_uart
module tb_pc_trace_uart;

  localparam int BAUD = 4;

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  int         checks = 0;
  int         errors = 0;
  logic [7:0] qa[$];
  logic [7:0] qb[$];

  pc_trace_uart_if #(.DEPTH_LOG2(2)) ifa ();
  pc_trace_uart_if #(.DEPTH_LOG2(2)) ifb ();

  pc_trace_uart #(.BAUD_DIV(BAUD), .DEPTH_LOG2(2), .STALL_MODE(0)) dut_a (
    .clk_in (clk),
    .reset  (reset),
    .tif    (ifa)
  );

  pc_trace_uart #(.BAUD_DIV(BAUD), .DEPTH_LOG2(2), .STALL_MODE(1)) dut_b (
    .clk_in (clk),
    .reset  (reset),
    .tif    (ifb)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] rec_byte(input logic [31:0] p, input logic [31:0] n, input int k);
    logic [63:0] r;
    r = {p, n};
    if (k == 0) return 8'hA5;
    return r[(71 - 8 * k) -: 8];
  endfunction

  function automatic logic [31:0] tpc(input int i);
    return 32'h0040_0100 + 32'(4 * i);
  endfunction

  function automatic logic [31:0] tinst(input int i);
    return 32'h1000_0000 + 32'(i);
  endfunction

  task automatic wait_bytes(input bit use_b, input int n);
    int g;
    g = 0;
    while (((use_b ? qb.size() : qa.size()) < n) && g < 6000) begin
      @(negedge clk);
      g++;
    end
    check("bytes_avail", 64'((use_b ? qb.size() : qa.size()) >= n), 64'd1);
  endtask

  task automatic check_rec(input bit use_b, input int base, input int rn,
                           input logic [31:0] p, input logic [31:0] n);
    logic [7:0] obs;
    for (int k = 0; k < 9; k++) begin
      obs = use_b ? qb[base + 9 * rn + k] : qa[base + 9 * rn + k];
      check($sformatf("%s_rec%0d_byte%0d", use_b ? "b" : "a", rn, k), 64'(obs), 64'(rec_byte(p, n, k)));
    end
  endtask

  // UART receiver for DUT A: samples each bit near its middle
  initial begin : dec_a
    logic [7:0] b;
    b = '0;
    forever begin
      @(negedge clk);
      if (!reset && ifa.tx === 1'b0) begin
        repeat (BAUD + 1) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          b[i] = ifa.tx;
          if (i < 7) repeat (BAUD) @(negedge clk);
        end
        repeat (BAUD) @(negedge clk);
        check("stop_bit_a", 64'(ifa.tx), 64'd1);
        qa.push_back(b);
      end
    end
  end

  // UART receiver for DUT B
  initial begin : dec_b
    logic [7:0] b;
    b = '0;
    forever begin
      @(negedge clk);
      if (!reset && ifb.tx === 1'b0) begin
        repeat (BAUD + 1) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          b[i] = ifb.tx;
          if (i < 7) repeat (BAUD) @(negedge clk);
        end
        repeat (BAUD) @(negedge clk);
        check("stop_bit_b", 64'(ifb.tx), 64'd1);
        qb.push_back(b);
      end
    end
  end

  initial begin : main
    logic [7:0] exp1 [9];
    logic [7:0] exp5 [9];
    int         base;
    int         g;

    exp1 = '{8'hA5, 8'h00, 8'h40, 8'h00, 8'h00, 8'h20, 8'h08, 8'h00, 8'h05};
    exp5 = '{8'hA5, 8'h00, 8'h40, 8'h00, 8'h04, 8'h00, 8'h00, 8'h00, 8'h13};

    ifa.pc = '0; ifa.inst = '0; ifa.trace_en = 1'b0;
    ifb.pc = '0; ifb.inst = '0; ifb.trace_en = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("rst_tx",       64'(ifa.tx),         64'd1);
    check("rst_hold",     64'(ifa.hold),       64'd0);
    check("rst_busy",     64'(ifa.busy),       64'd0);
    check("rst_overflow", 64'(ifa.overflow),   64'd0);
    check("rst_drop",     64'(ifa.drop_cnt),   64'd0);
    check("rst_level",    64'(ifa.fifo_level), 64'd0);
    check("rst_tx_b",     64'(ifb.tx),         64'd1);
    check("rst_hold_b",   64'(ifb.hold),       64'd0);

    // Test 1: single record, byte content and busy duration
    base = qa.size();
    ifa.pc = 32'h0040_0000; ifa.inst = 32'h2008_0005; ifa.trace_en = 1'b1;
    @(negedge clk);
    check("t1_level_push", 64'(ifa.fifo_level), 64'd1);
    check("t1_tx_idle",    64'(ifa.tx),         64'd1);
    ifa.trace_en = 1'b0;
    @(negedge clk);
    check("t1_start_bit",  64'(ifa.tx),         64'd0);
    check("t1_level_pop",  64'(ifa.fifo_level), 64'd0);
    check("t1_busy_start", 64'(ifa.busy),       64'd1);
    repeat (359) @(negedge clk);
    check("t1_busy_359",   64'(ifa.busy),       64'd1);
    @(negedge clk);
    check("t1_busy_360",   64'(ifa.busy),       64'd0);
    wait_bytes(1'b0, base + 9);
    for (int k = 0; k < 9; k++) begin
      check($sformatf("t1_byte%0d", k), 64'(qa[base + k]), 64'(exp1[k]));
    end

    // Test 2: pc held for 50 cycles yields one record
    base = qa.size();
    ifa.pc = 32'h0040_0010; ifa.inst = 32'h0000_0013; ifa.trace_en = 1'b1;
    repeat (50) @(negedge clk);
    ifa.trace_en = 1'b0;
    repeat (420) @(negedge clk);
    check("t2_nbytes", 64'(qa.size() - base), 64'd9);
    check("t2_drop",   64'(ifa.drop_cnt),     64'd0);
    check("t2_busy",   64'(ifa.busy),         64'd0);
    check_rec(1'b0, base, 0, 32'h0040_0010, 32'h0000_0013);

    // Test 3: ten new pcs back to back, drop mode
    base = qa.size();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 2) check("t3_start_bit", 64'(ifa.tx), 64'd0);
      ifa.pc = tpc(i); ifa.inst = tinst(i); ifa.trace_en = 1'b1;
    end
    @(negedge clk);
    ifa.trace_en = 1'b0;
    check("t3_level",    64'(ifa.fifo_level), 64'd4);
    check("t3_overflow", 64'(ifa.overflow),   64'd1);
    check("t3_drop",     64'(ifa.drop_cnt),   64'd5);
    check("t3_hold",     64'(ifa.hold),       64'd0);

    // Test 6: capture on the cycle the next pop happens while full
    repeat (352) @(negedge clk);
    check("t6_level_pre", 64'(ifa.fifo_level), 64'd4);
    check("t6_tx_gap",    64'(ifa.tx),         64'd1);
    ifa.pc = 32'h0040_0200; ifa.inst = 32'hDEAD_BEEF; ifa.trace_en = 1'b1;
    @(negedge clk);
    ifa.trace_en = 1'b0;
    check("t6_level_post", 64'(ifa.fifo_level), 64'd4);
    check("t6_drop",       64'(ifa.drop_cnt),   64'd5);
    check("t6_start_bit",  64'(ifa.tx),         64'd0);
    wait_bytes(1'b0, base + 54);
    for (int r = 0; r < 5; r++) check_rec(1'b0, base, r, tpc(r), tinst(r));
    check_rec(1'b0, base, 5, 32'h0040_0200, 32'hDEAD_BEEF);
    repeat (5) @(negedge clk);
    check("t6_busy_end", 64'(ifa.busy), 64'd0);

    // Test 5: reset during the data bits of byte 3
    ifa.pc = 32'h0040_0300; ifa.inst = 32'h1111_2222; ifa.trace_en = 1'b1;
    @(negedge clk);
    ifa.trace_en = 1'b0;
    @(negedge clk);
    check("t5_start_bit", 64'(ifa.tx), 64'd0);
    repeat (138) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("t5_tx",       64'(ifa.tx),         64'd1);
    check("t5_level",    64'(ifa.fifo_level), 64'd0);
    check("t5_busy",     64'(ifa.busy),       64'd0);
    check("t5_overflow", 64'(ifa.overflow),   64'd0);
    check("t5_drop",     64'(ifa.drop_cnt),   64'd0);
    repeat (60) @(negedge clk);
    check("t5_tx_quiet", 64'(ifa.tx),   64'd1);
    check("t5_busy_q",   64'(ifa.busy), 64'd0);
    base = qa.size();
    ifa.pc = 32'h0040_0004; ifa.inst = 32'h0000_0013; ifa.trace_en = 1'b1;
    @(negedge clk);
    ifa.trace_en = 1'b0;
    wait_bytes(1'b0, base + 9);
    for (int k = 0; k < 9; k++) begin
      check($sformatf("t5_byte%0d", k), 64'(qa[base + k]), 64'(exp5[k]));
    end

    // Test 4: stall mode, pc frozen while hold is asserted
    base = qb.size();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      g = 0;
      while (ifb.hold === 1'b1 && g < 2000) begin
        check("t4_hold_level", 64'(ifb.fifo_level), 64'd4);
        @(negedge clk);
        g++;
      end
      check("t4_hold_bound", 64'(g < 2000), 64'd1);
      if (i == 5) check("t4_hold_wait", 64'(g > 0), 64'd1);
      ifb.pc = tpc(i); ifb.inst = tinst(i); ifb.trace_en = 1'b1;
    end
    @(negedge clk);
    ifb.trace_en = 1'b0;
    check("t4_drop",     64'(ifb.drop_cnt), 64'd0);
    check("t4_overflow", 64'(ifb.overflow), 64'd0);
    wait_bytes(1'b1, base + 90);
    for (int r = 0; r < 10; r++) check_rec(1'b1, base, r, tpc(r), tinst(r));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_trace_uart.md
Name: pc_trace_uart

Overview:
- Commit-trace stage directly downstream of the single-cycle computer top.
- Consumes its pc/inst outputs and buffers retired {pc, inst} records in a small FIFO.
- Serialises the records over a UART 8N1 line for board-level debug.
- Optional hold output can drive the CPU enable so that no record is lost.

Parameters:
- BAUD_DIV, 868: clocks per UART bit (100 MHz / 115200); legal range >= 2.
- DEPTH_LOG2, 4: FIFO depth = 2^DEPTH_LOG2 records.
- STALL_MODE, 0: 1 = assert hold when the FIFO is full instead of dropping records.

Ports:
- clk_in, input, 1: system clock; all logic is on the rising edge.
- reset, input, 1: synchronous, active-high reset.
- pc, input, 32: current PC from the computer top.
- inst, input, 32: instruction at pc.
- trace_en, input, 1: capture enable.
- tx, output, 1: UART serial out; idle high.
- hold, output, 1: request to deassert CPU enable (STALL_MODE=1 only; otherwise constant 0).
- busy, output, 1: FIFO non-empty or transmitter not idle.
- overflow, output, 1: sticky; set when a record is dropped.
- drop_cnt, output, 16: count of dropped records; saturates at 16'hFFFF.
- fifo_level, output, DEPTH_LOG2+1: current FIFO occupancy.

Behaviour:
- Reset is synchronous and active-high. Values the cycle after reset: tx=1, hold=0, busy=0, overflow=0, drop_cnt=0, fifo_level=0. FIFO empty, TX FSM in IDLE, last_valid=0.
- Reset asserted mid-frame aborts the frame. tx is high on the next cycle and no partial byte resumes.
- Capture condition: trace_en=1 and (last_valid=0 or pc != last_pc). On capture, set last_pc<=pc and last_valid<=1. A PC held by a stall or a self-jump therefore produces exactly one record.
- Push: a captured record is written at the same edge it is captured.
- Push when the FIFO is full and no pop happens that cycle:
  - STALL_MODE=0: the record is dropped, overflow<=1, drop_cnt increments (saturating). last_pc still updates.
  - STALL_MODE=1: the same drop rules apply, but that case should not arise while hold is honoured.
- Push and pop in the same cycle while full: the push is accepted and the level is unchanged.
- hold = STALL_MODE & (fifo_level == 2^DEPTH_LOG2), combinational from the registered level.
- FIFO pointers are DEPTH_LOG2+1 bits and wrap modulo 2^(DEPTH_LOG2+1). Full means the MSBs differ and the low bits are equal.
- Record transmission is 9 bytes: SYNC 8'hA5, then pc[31:24], pc[23:16], pc[15:8], pc[7:0], then inst[31:24] down to inst[7:0].
- Each byte is 8N1: start bit 0, data bits LSB first, stop bit 1. Every bit lasts exactly BAUD_DIV clocks.
- TX FSM states:
  - IDLE: if the FIFO is non-empty, pop into the 64-bit shift register and go to START with byte index 0.
  - START: drive 0 for BAUD_DIV clocks, then go to DATA.
  - DATA: drive 8 bits, then go to STOP.
  - STOP: drive 1 for BAUD_DIV clocks. If byte index < 8, increment it and go to START; otherwise go to IDLE.
- Latency: the pop happens in the first IDLE cycle with the FIFO non-empty, and the start bit appears on tx the next cycle.
- A record takes exactly 90*BAUD_DIV clocks. IDLE adds one gap cycle between records.
- Back-to-back records arrive as IDLE (1 cycle) then START; there is no extra idle bit.
- busy = (fifo_level != 0) | (state != IDLE).

Decomposition:
- Package trace_pkg contains:
  - SYNC_BYTE = 8'hA5, REC_W = 64, BYTES_PER_REC = 9.
  - The TX FSM state enum {IDLE, START, DATA, STOP}.
- Sub-module uart_tx_byte: byte serialiser with its own baud counter.
  - Interface: start/data[7:0] in, done pulse out, tx out.
  - The top keeps the FIFO, capture logic, and the byte sequencer.

Test Plan (BAUD_DIV=4, DEPTH_LOG2=2 unless stated):
1. Reset, then one capture of pc=32'h0040_0000, inst=32'h2008_0005, then trace_en=0.
   - Decoded tx bytes are A5 00 40 00 00 20 08 00 05.
   - busy falls exactly 360 cycles after the start bit of A5.
2. pc held at 32'h0040_0010 for 50 cycles with trace_en=1.
   - Exactly one record is sent; drop_cnt=0.
3. STALL_MODE=0, new pc on every one of 10 consecutive cycles.
   - FIFO accepts 4 records plus the 1 already popped into the shifter.
   - overflow=1, drop_cnt=5.
   - tx emits 5 complete records in push order.
4. STALL_MODE=1, same stimulus as test 3, with pc frozen while hold=1.
   - hold asserts when fifo_level=4; drop_cnt stays 0.
   - All 10 records are sent in order.
5. Reset asserted during the DATA bits of byte 3.
   - Next cycle: tx=1, fifo_level=0, busy=0.
   - A following capture of pc=32'h0040_0004 produces a clean frame beginning A5.
6. Capture on the exact cycle a pop occurs while full.
   - The push is accepted, fifo_level stays 4, and no drop is recorded.
